// File: rtl/recv_pkg.sv
// Shared definitions for the receive-side match table.
//   - default packet and source-id widths
//   - the packet header codes
//   - the controller FSM state type
package recv_pkg;

    localparam int PKT_W_DEF = 128;
    localparam int SRC_W_DEF = 2;

    localparam logic [4:0] HDR_EAGER = 5'b10000;
    localparam logic [4:0] HDR_RTS   = 5'b10001;
    localparam logic [4:0] HDR_CTS   = 5'b01110;
    localparam logic [4:0] HDR_DATA  = 5'b11000;

    // IDLE is encoded as zero, so a reset leaves the debug state output at zero.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_RSP  = 2'd3
    } state_t;

endpackage

// File: rtl/match_table_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter for the match table controller.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   i_req_net      : network store is eligible this cycle
//   i_req_fnd      : finder lookup is eligible this cycle
//   o_gnt_net      : network store granted (combinational)
//   o_gnt_fnd      : finder lookup granted (combinational)
// A lone requester always wins. When both request, the one that did not win
// last time wins. Out of reset the network side has priority.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic i_req_net,
    input  logic i_req_fnd,
    output logic o_gnt_net,
    output logic o_gnt_fnd
);

    // 1: net wins a tie next time, 0: finder wins a tie next time.
    logic r_prio_net;

    always_comb begin
        o_gnt_net = i_req_net & (~i_req_fnd | r_prio_net);
        o_gnt_fnd = i_req_fnd & ~o_gnt_net;
    end

    // Requests already include valid and IDLE, so a grant is a handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio_net <= 1'b1;
        end else if (o_gnt_net) begin
            r_prio_net <= 1'b0;
        end else if (o_gnt_fnd) begin
            r_prio_net <= 1'b1;
        end
    end

endmodule

// File: rtl/match_table_ctrl.sv
// Match table controller: stores one eager/RTS packet per source in an
// external table RAM and serves finder lookups that consume the stored entry.
// Ports:
//   nios_clk, reset          : clock (rising edge), asynchronous active-high reset
//   net_valid/src/packet     : network store request; net_ready accepts it
//   fnd_valid/src            : finder lookup request; fnd_ready accepts it
//   fnd_rsp_valid/hit/packet : one-cycle lookup response (packet zero on a miss)
//   tbl_we/re/addr/wdata     : external table RAM port
//   tbl_rdata                : RAM read data, valid the cycle after tbl_re
//   occupancy                : per-source valid bits
//   dbg_state                : current FSM state, for observation only
// Handshake: a request is taken in the cycle where its valid and ready are
// both high. Ready is combinational, only ever high in IDLE, and only for the
// arbitration winner; a network request targeting an occupied slot is not
// eligible and waits, with ready low, until a finder hit frees the slot.
module match_table_ctrl
    import recv_pkg::*;
#(
    parameter int PKT_W = PKT_W_DEF,
    parameter int SRC_W = SRC_W_DEF
) (
    input  logic                  nios_clk,
    input  logic                  reset,
    input  logic                  net_valid,
    input  logic [SRC_W-1:0]      net_src,
    input  logic [PKT_W-1:0]      net_packet,
    output logic                  net_ready,
    input  logic                  fnd_valid,
    input  logic [SRC_W-1:0]      fnd_src,
    output logic                  fnd_ready,
    output logic                  fnd_rsp_valid,
    output logic                  fnd_rsp_hit,
    output logic [PKT_W-1:0]      fnd_rsp_packet,
    output logic                  tbl_we,
    output logic                  tbl_re,
    output logic [SRC_W-1:0]      tbl_addr,
    output logic [PKT_W-1:0]      tbl_wdata,
    input  logic [PKT_W-1:0]      tbl_rdata,
    output logic [(2**SRC_W)-1:0] occupancy,
    output logic [1:0]            dbg_state
);

    localparam int NSRC = 2 ** SRC_W;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [NSRC-1:0]  r_valid;
    logic [SRC_W-1:0] r_src;
    logic [PKT_W-1:0] r_pkt;
    logic             r_hit;

    logic w_in_idle;
    logic w_req_net;
    logic w_req_fnd;
    logic w_gnt_net;
    logic w_gnt_fnd;

    assign w_in_idle = (r_state == ST_IDLE);
    assign w_req_net = w_in_idle & net_valid & ~r_valid[net_src];
    assign w_req_fnd = w_in_idle & fnd_valid;

    rr_arb2 u_arb (
        .clk       (nios_clk),
        .rst       (reset),
        .i_req_net (w_req_net),
        .i_req_fnd (w_req_fnd),
        .o_gnt_net (w_gnt_net),
        .o_gnt_fnd (w_gnt_fnd)
    );

    // Readies are masked while reset is held so every output is zero in reset.
    assign net_ready = w_gnt_net & ~reset;
    assign fnd_ready = w_gnt_fnd & ~reset;
    assign occupancy = r_valid;
    assign dbg_state = r_state;

    always_ff @(posedge nios_clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_valid <= '0;
            r_src   <= '0;
            r_pkt   <= '0;
            r_hit   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_gnt_net) begin
                r_src <= net_src;
                r_pkt <= net_packet;
            end else if (w_gnt_fnd) begin
                r_src <= fnd_src;
                r_hit <= r_valid[fnd_src];
            end
            if (r_state == ST_WR) begin
                r_valid[r_src] <= 1'b1;
            end
            // A hit consumes the entry as the response goes out.
            if ((r_state == ST_RSP) && r_hit) begin
                r_valid[r_src] <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        tbl_we         = 1'b0;
        tbl_re         = 1'b0;
        tbl_addr       = '0;
        tbl_wdata      = '0;
        fnd_rsp_valid  = 1'b0;
        fnd_rsp_hit    = 1'b0;
        fnd_rsp_packet = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_net) begin
                    w_state_nxt = ST_WR;
                end else if (w_gnt_fnd) begin
                    // A miss skips the RAM entirely and answers next cycle.
                    w_state_nxt = r_valid[fnd_src] ? ST_RD : ST_RSP;
                end
            end
            ST_WR: begin
                tbl_we      = 1'b1;
                tbl_addr    = r_src;
                tbl_wdata   = r_pkt;
                w_state_nxt = ST_IDLE;
            end
            ST_RD: begin
                tbl_re      = 1'b1;
                tbl_addr    = r_src;
                w_state_nxt = ST_RSP;
            end
            ST_RSP: begin
                fnd_rsp_valid  = 1'b1;
                fnd_rsp_hit    = r_hit;
                fnd_rsp_packet = r_hit ? tbl_rdata : '0;
                w_state_nxt    = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_match_table_ctrl.sv
module tb_match_table_ctrl;

  localparam int PKT_W = 128;
  localparam int SRC_W = 2;
  localparam int NSRC  = 4;

  logic               nios_clk = 1'b0;
  logic               reset = 1'b1;
  logic               net_valid = 1'b0;
  logic [SRC_W-1:0]   net_src = '0;
  logic [PKT_W-1:0]   net_packet = '0;
  logic               net_ready;
  logic               fnd_valid = 1'b0;
  logic [SRC_W-1:0]   fnd_src = '0;
  logic               fnd_ready;
  logic               fnd_rsp_valid;
  logic               fnd_rsp_hit;
  logic [PKT_W-1:0]   fnd_rsp_packet;
  logic               tbl_we;
  logic               tbl_re;
  logic [SRC_W-1:0]   tbl_addr;
  logic [PKT_W-1:0]   tbl_wdata;
  logic [PKT_W-1:0]   tbl_rdata = '0;
  logic [NSRC-1:0]    occupancy;
  logic [1:0]         dbg_state;

  // clock / reset block
  always #5 nios_clk = ~nios_clk;

  int cyc = 0;
  always @(posedge nios_clk) cyc <= cyc + 1;

  match_table_ctrl #(.PKT_W(PKT_W), .SRC_W(SRC_W)) dut (
    .nios_clk       (nios_clk),
    .reset          (reset),
    .net_valid      (net_valid),
    .net_src        (net_src),
    .net_packet     (net_packet),
    .net_ready      (net_ready),
    .fnd_valid      (fnd_valid),
    .fnd_src        (fnd_src),
    .fnd_ready      (fnd_ready),
    .fnd_rsp_valid  (fnd_rsp_valid),
    .fnd_rsp_hit    (fnd_rsp_hit),
    .fnd_rsp_packet (fnd_rsp_packet),
    .tbl_we         (tbl_we),
    .tbl_re         (tbl_re),
    .tbl_addr       (tbl_addr),
    .tbl_wdata      (tbl_wdata),
    .tbl_rdata      (tbl_rdata),
    .occupancy      (occupancy),
    .dbg_state      (dbg_state)
  );

  // external table RAM, one cycle read latency
  logic [PKT_W-1:0] ram [NSRC];
  always @(posedge nios_clk) begin
    if (tbl_we) ram[tbl_addr] <= tbl_wdata;
    if (tbl_re) tbl_rdata <= ram[tbl_addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [PKT_W-1:0] rand_pkt();
    logic [PKT_W-1:0] p;
    for (int i = 0; i < PKT_W / 32; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  // scoreboard queues: expected item plus the cycle it must appear in
  logic [PKT_W:0]         exp_q[$];
  int                     exp_cyc_q[$];
  logic [SRC_W+PKT_W-1:0] wr_q[$];
  int                     wr_cyc_q[$];
  logic [SRC_W-1:0]       rd_q[$];
  int                     rd_cyc_q[$];

  // reference model: table contents, occupancy, tie-break owner, busy cycles
  logic [NSRC-1:0]  m_valid;
  logic [PKT_W-1:0] m_store [NSRC];
  logic             m_net_prio;
  int               m_busy;
  logic             m_gn, m_gf;

  logic [PKT_W:0]         e_rsp;
  logic [SRC_W+PKT_W-1:0] e_wr;
  logic [SRC_W-1:0]       e_rd;
  int                     e_c;

  // monitor + model, sampled on the falling edge
  initial begin
    forever begin
      @(negedge nios_clk);
      if (reset) begin
        chk("rst_net_ready", net_ready, 0);
        chk("rst_fnd_ready", fnd_ready, 0);
        chk("rst_rsp", {fnd_rsp_valid, fnd_rsp_hit, fnd_rsp_packet}, 0);
        chk("rst_tbl", {tbl_we, tbl_re, tbl_addr, tbl_wdata}, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_state", dbg_state, 0);
        exp_q.delete(); exp_cyc_q.delete();
        wr_q.delete();  wr_cyc_q.delete();
        rd_q.delete();  rd_cyc_q.delete();
        m_valid = '0; m_busy = 0; m_net_prio = 1'b1;
      end else begin
        chk("we_re_exclusive", tbl_we & tbl_re, 0);
        if (tbl_we || (wr_cyc_q.size() > 0 && wr_cyc_q[0] <= cyc)) begin
          if (wr_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL wr_unexpected: got write addr %0d expected none (cycle %0d)", tbl_addr, cyc);
          end else begin
            e_wr = wr_q.pop_front(); e_c = wr_cyc_q.pop_front();
            chk("wr_strobe", tbl_we, 1);
            chk("wr_cycle", cyc, e_c);
            chk("wr_addr_data", {tbl_addr, tbl_wdata}, e_wr);
          end
        end
        if (tbl_re || (rd_cyc_q.size() > 0 && rd_cyc_q[0] <= cyc)) begin
          if (rd_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL rd_unexpected: got read addr %0d expected none (cycle %0d)", tbl_addr, cyc);
          end else begin
            e_rd = rd_q.pop_front(); e_c = rd_cyc_q.pop_front();
            chk("rd_strobe", tbl_re, 1);
            chk("rd_cycle", cyc, e_c);
            chk("rd_addr", tbl_addr, e_rd);
          end
        end
        if (!tbl_we) chk("wdata_zero", tbl_wdata, 0);
        if (!tbl_we && !tbl_re) chk("addr_zero", tbl_addr, 0);
        if (fnd_rsp_valid || (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc)) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL rsp_unexpected: got hit %0b expected no response (cycle %0d)", fnd_rsp_hit, cyc);
          end else begin
            e_rsp = exp_q.pop_front(); e_c = exp_cyc_q.pop_front();
            chk("rsp_valid", fnd_rsp_valid, 1);
            chk("rsp_cycle", cyc, e_c);
            chk("rsp_hit_packet", {fnd_rsp_hit, fnd_rsp_packet}, e_rsp);
          end
        end else begin
          chk("rsp_idle_zero", {fnd_rsp_hit, fnd_rsp_packet}, 0);
        end

        if (m_busy > 0) begin
          chk("net_ready_busy", net_ready, 0);
          chk("fnd_ready_busy", fnd_ready, 0);
          m_busy--;
        end else begin
          m_gn = net_valid && !m_valid[net_src] && (!fnd_valid || m_net_prio);
          m_gf = fnd_valid && !m_gn;
          chk("net_ready", net_ready, m_gn);
          chk("fnd_ready", fnd_ready, m_gf);
          chk("occupancy", occupancy, m_valid);
          if (m_gn) begin
            wr_q.push_back({net_src, net_packet}); wr_cyc_q.push_back(cyc + 1);
            m_valid[net_src] = 1'b1;
            m_store[net_src] = net_packet;
            m_net_prio = 1'b0;
            m_busy = 1;
          end else if (m_gf) begin
            m_net_prio = 1'b1;
            if (m_valid[fnd_src]) begin
              rd_q.push_back(fnd_src); rd_cyc_q.push_back(cyc + 1);
              exp_q.push_back({1'b1, m_store[fnd_src]}); exp_cyc_q.push_back(cyc + 2);
              m_valid[fnd_src] = 1'b0;
              m_busy = 2;
            end else begin
              exp_q.push_back({1'b0, {PKT_W{1'b0}}}); exp_cyc_q.push_back(cyc + 1);
              m_busy = 1;
            end
          end
        end
      end
    end
  end

  // driver tasks
  task automatic to_neg_of(input int c);
    do @(negedge nios_clk); while (cyc < c);
  endtask

  task automatic do_reset();
    @(negedge nios_clk); #1;
    reset = 1'b1; net_valid = 1'b0; fnd_valid = 1'b0;
    repeat (2) @(negedge nios_clk);
    #1 reset = 1'b0;
  endtask

  task automatic net_req(input logic [SRC_W-1:0] s, input logic [PKT_W-1:0] p, output int hs);
    @(posedge nios_clk); #1;
    net_valid = 1'b1; net_src = s; net_packet = p;
    hs = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge nios_clk);
      if (net_ready) begin hs = cyc; break; end
    end
    n_checks++;
    if (hs < 0) begin n_errors++; $display("FAIL net_handshake_timeout: got no ready expected ready"); end
    @(posedge nios_clk); #1;
    net_valid = 1'b0; net_src = '0; net_packet = '0;
  endtask

  task automatic fnd_req(input logic [SRC_W-1:0] s, output int hs);
    @(posedge nios_clk); #1;
    fnd_valid = 1'b1; fnd_src = s;
    hs = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge nios_clk);
      if (fnd_ready) begin hs = cyc; break; end
    end
    n_checks++;
    if (hs < 0) begin n_errors++; $display("FAIL fnd_handshake_timeout: got no ready expected ready"); end
    @(posedge nios_clk); #1;
    fnd_valid = 1'b0; fnd_src = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [PKT_W-1:0] p1;
  int t, tf, tn;
  int grants[$];
  logic chg;

  initial begin
    for (int i = 0; i < NSRC; i++) ram[i] = rand_pkt();
    p1 = '0; p1[PKT_W-1] = 1'b1; p1[7:0] = 8'hAB;

    // requests held during reset must not be accepted
    net_valid = 1'b1; net_src = 2; fnd_valid = 1'b1; fnd_src = 1;
    repeat (3) @(negedge nios_clk);
    #1; reset = 1'b0; net_valid = 1'b0; fnd_valid = 1'b0; net_src = '0; fnd_src = '0;

    // store src 2
    net_req(2, p1, t);
    to_neg_of(t + 1);
    chk("store_we", tbl_we, 1);
    chk("store_addr", tbl_addr, 2);
    to_neg_of(t + 2);
    chk("store_occupancy", occupancy, 4'b0100);

    // finder hit on src 2
    fnd_req(2, t);
    to_neg_of(t + 1);
    chk("hit_re", tbl_re, 1);
    to_neg_of(t + 2);
    chk("hit_rsp", {fnd_rsp_valid, fnd_rsp_hit, fnd_rsp_packet}, {2'b11, p1});
    to_neg_of(t + 3);
    chk("hit_occupancy", occupancy, 0);

    // finder miss on empty table
    fnd_req(1, t);
    to_neg_of(t + 1);
    chk("miss_rsp", {fnd_rsp_valid, fnd_rsp_hit, fnd_rsp_packet}, {2'b10, {PKT_W{1'b0}}});
    chk("miss_no_re", tbl_re, 0);

    // both requesting continuously from reset: grants alternate
    do_reset();
    @(posedge nios_clk); #1;
    net_valid = 1'b1; net_src = 0; net_packet = rand_pkt();
    fnd_valid = 1'b1; fnd_src = 1;
    grants.delete();
    for (int i = 0; i < 60; i++) begin
      @(negedge nios_clk);
      chg = 1'b0;
      if (net_ready) begin grants.push_back(0); chg = 1'b1; end
      if (fnd_ready) grants.push_back(1);
      if (grants.size() >= 4) break;
      @(posedge nios_clk); #1;
      if (chg) begin net_src = 3; net_packet = rand_pkt(); end
    end
    @(posedge nios_clk); #1;
    net_valid = 1'b0; fnd_valid = 1'b0; net_src = '0; fnd_src = '0;
    while (grants.size() < 4) grants.push_back(-1);
    chk("rr_grant0", grants[0], 0);
    chk("rr_grant1", grants[1], 1);
    chk("rr_grant2", grants[2], 0);
    chk("rr_grant3", grants[3], 1);

    // src 0 occupied: network stalls until the finder consumes it
    @(posedge nios_clk); #1;
    net_valid = 1'b1; net_src = 0; net_packet = rand_pkt();
    for (int i = 0; i < 5; i++) begin
      @(negedge nios_clk);
      chk("net_stall", net_ready, 0);
    end
    @(posedge nios_clk); #1;
    fnd_valid = 1'b1; fnd_src = 0;
    tf = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge nios_clk);
      if (fnd_ready) begin tf = cyc; break; end
    end
    @(posedge nios_clk); #1;
    fnd_valid = 1'b0; fnd_src = '0;
    tn = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge nios_clk);
      if (net_ready) begin tn = cyc; break; end
    end
    @(posedge nios_clk); #1;
    net_valid = 1'b0; net_src = '0;
    chk("stall_fnd_granted", tf >= 0, 1);
    chk("net_after_hit", tn, tf + 3);
    to_neg_of(tn + 2);
    chk("stall_occupancy", occupancy, 4'b1001);

    // reset during RD aborts the lookup
    fnd_req(3, t);
    to_neg_of(t + 1);
    chk("abort_in_rd", tbl_re, 1);
    #1 reset = 1'b1;
    #1;
    chk("abort_outputs", {net_ready, fnd_ready, fnd_rsp_valid, fnd_rsp_hit, fnd_rsp_packet}, 0);
    chk("abort_tbl", {tbl_we, tbl_re, tbl_addr, tbl_wdata}, 0);
    chk("abort_occupancy", occupancy, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge nios_clk);
      chk("abort_no_rsp", fnd_rsp_valid, 0);
    end
    #1 reset = 1'b0;

    // randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      @(posedge nios_clk); #1;
      net_valid  = ($urandom_range(0, 99) < 55);
      net_src    = SRC_W'($urandom_range(0, NSRC - 1));
      net_packet = rand_pkt();
      fnd_valid  = ($urandom_range(0, 99) < 40);
      fnd_src    = SRC_W'($urandom_range(0, NSRC - 1));
    end
    @(posedge nios_clk); #1;
    net_valid = 1'b0; fnd_valid = 1'b0;
    repeat (8) @(negedge nios_clk);
    chk("drain_rsp_q", exp_q.size(), 0);
    chk("drain_wr_q", wr_q.size(), 0);
    chk("drain_rd_q", rd_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
